vga_sync: RTL
=============

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL take parameters H_DISPLAY 640, H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal visible, front porch, sync and back porch widths in pixel clocks.
REQ-002 The block SHALL take parameters V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical visible, front porch, sync and back porch heights in lines.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_d  input  1  pixel clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pixel_x  output  10  horizontal counter, 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (default 800).
REQ-007 pixel_y  output  10  vertical counter, 0..V_TOTAL-1, where V_TOTAL = sum of the four V parameters (default 525).
REQ-008 video_on  output  1  high when the current pixel_x/pixel_y lies in the visible region.
REQ-009 hsync  output  1  horizontal sync, active low.
REQ-010 vsync  output  1  vertical sync, active low.
REQ-011 line_tick  output  1  one-cycle pulse at the start of every line.
REQ-012 frame_tick  output  1  one-cycle pulse at the start of vertical blanking, for game-state update.

Function
REQ-013 pixel_x SHALL increment by 1 every clk_d cycle and wrap from H_TOTAL-1 to 0.
REQ-014 pixel_y SHALL increment by 1 on the cycle pixel_x wraps, hold otherwise, and wrap from V_TOTAL-1 to 0 when both counters are at their maximum.
REQ-015 Counters SHALL never hold values outside 0..H_TOTAL-1 / 0..V_TOTAL-1.
REQ-016 video_on, line_tick and frame_tick SHALL be registered decodes of the next counter values, so they are cycle-aligned with pixel_x/pixel_y (zero relative latency).
REQ-017 video_on SHALL be 1 iff pixel_x < H_DISPLAY and pixel_y < V_DISPLAY, except as in REQ-026.
REQ-018 line_tick SHALL be 1 iff pixel_x == 0, except as in REQ-026.
REQ-019 frame_tick SHALL be 1 iff pixel_x == 0 and pixel_y == V_DISPLAY; exactly once per frame.
REQ-020 The internal sync condition SHALL be: horizontal active for pixel_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (default 656..751); vertical active for pixel_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (default 490..491).
REQ-021 hsync and vsync SHALL be driven low one clk_d cycle after their sync condition holds, matching the one-cycle colour register of the downstream screen renderer (default: hsync low while pixel_x is 657..752, including wrap handling).
REQ-022 hsync SHALL be low for exactly H_SYNC consecutive cycles per line.
REQ-023 vsync SHALL be low for exactly V_SYNC*H_TOTAL consecutive cycles per frame.
REQ-024 All outputs SHALL be glitch-free register outputs; no combinational path from counters to ports.

Reset
REQ-025 On rst_n low, asynchronously: pixel_x=0, pixel_y=0, video_on=0, line_tick=0, frame_tick=0, hsync=1, vsync=1.
REQ-026 In the first cycle after rst_n deasserts, outputs SHALL hold their reset values, so pixel (0,0) of the first frame is blanked with no line_tick; normal decode applies from the second cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; counting restarts at (0,0) on release with no partial sync pulse.

Verification
REQ-028 Reset release: hold rst_n=0 for 5 cycles, then release -> first edge: x=0, y=0, video_on=0, hsync=vsync=1; next edge: x=1, video_on=1.
REQ-029 Line timing: run 2 lines -> x wraps 799->0 while y goes 0->1; hsync low for exactly 96 cycles, first low when x==657; line_tick every 800 cycles.
REQ-030 Frame timing: run 2 frames -> frame_tick interval 420000 cycles at x=0, y=480; vsync low for 1600 cycles starting at y=490, x=1; y wraps 524->0.
REQ-031 Visible count: over one full frame, video_on high exactly 307200 cycles, 640 per line for y<480, and zero for y=480..524.
REQ-032 Mid-frame reset: assert rst_n=0 at x=300, y=200 -> all outputs take reset values immediately; after release, counting resumes from (0,0).
REQ-033 Parameter override: H_DISPLAY=8, H_FRONT=2, H_SYNC=3, H_BACK=1, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> H_TOTAL=14, V_TOTAL=7, hsync low 3 cycles starting at x=11.

Source files
------------

// File: rtl/vga_sync_if.sv
// Video timing bundle: counters, blanking and sync strobes from vga_sync to
// the renderer that consumes them.
interface vga_sync_if;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       line_tick;
   logic       frame_tick;

   modport master (
      output pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
   );

   modport slave (
      input  pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
   );
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel/line counters with registered visible,
// tick and sync decodes; sync is delayed one pixel to line up with the renderer.
module vga_sync #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk_d,
   input  logic        rst_n,
   vga_sync_if.master  vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
   localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic       run_q;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       video_q, video_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       line_q, line_d;
   logic       frame_q, frame_d;

   // run_q stays low for the first edge after reset so (0,0) is emitted blanked
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (run_q) begin
         if (x_q == H_MAX) begin
            x_d = '0;
            y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      video_d = run_q && (x_d < H_VIS) && (y_d < V_VIS);
      line_d  = run_q && (x_d == '0);
      frame_d = run_q && (x_d == '0) && (y_d == V_VIS);
      // sync decodes the current position, so the pin lags the counters by one pixel
      hsync_d = !(run_q && (x_q >= HS_LO) && (x_q <= HS_HI));
      vsync_d = !(run_q && (y_q >= VS_LO) && (y_q <= VS_HI));
   end

   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         video_q <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         x_q     <= x_d;
         y_q     <= y_d;
         video_q <= video_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign vga.pixel_x    = x_q;
   assign vga.pixel_y    = y_q;
   assign vga.video_on   = video_q;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.line_tick  = line_q;
   assign vga.frame_tick = frame_q;

endmodule
